// File: rtl/vmem_port_arbiter.sv
// Round-robin, work-conserving share of memory_slice port 0 among NREQ requesters.
// An in-order tag FIFO remembers who issued each read so responses route back to that requester.
module vmem_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NREQ*AW-1:0]             req_addr,
    input  logic [NREQ*DW-1:0]             req_data,
    input  logic [NREQ-1:0]                req_we,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    output logic [DW-1:0]                  rsp_data,
    output logic [AW-1:0]                  rsp_addr,
    output logic [NREQ-1:0]                rsp_valid,
    input  logic [NREQ-1:0]                rsp_ready,
    output logic [AW-1:0]                  m_addr,
    output logic [DW-1:0]                  m_data,
    output logic                           m_we,
    output logic                           m_valid,
    input  logic                           m_ready,
    input  logic [AW-1:0]                  s_addr,
    input  logic [DW-1:0]                  s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
    output logic                           err_orphan
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = $clog2(TAG_DEPTH+1);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] tag_mem_q [TAG_DEPTH];
    logic [IW-1:0] tag_mem_d [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_orphan_q, err_orphan_d;

    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];
    logic [NREQ-1:0] elig;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   head;
    logic            gnt_any;
    logic            tag_full;
    logic            tag_empty;
    logic            accept;
    logic            push;
    logic            pop;

    assign tag_empty = (cnt_q == '0);
    assign tag_full  = (cnt_q == CW'(TAG_DEPTH));
    assign head      = tag_mem_q[rd_ptr_q];

    // Full tag FIFO only holds back reads; eligibility never looks at s_valid.
    for (genvar k = 0; k < NREQ; k++) begin : g_req
        assign addr_a[k] = req_addr[k*AW +: AW];
        assign data_a[k] = req_data[k*DW +: DW];
        assign elig[k]   = req_valid[k] && (req_we[k] || !tag_full);
    end

    always_comb begin
        logic [IW:0] k;
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (k >= (IW+1)'(NREQ)) k = k - (IW+1)'(NREQ);
            if (!gnt_any && elig[k[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = k[IW-1:0];
            end
        end
    end

    always_comb begin
        m_valid   = reset_n && gnt_any;
        m_addr    = addr_a[gnt_idx];
        m_data    = data_a[gnt_idx];
        m_we      = req_we[gnt_idx];
        req_ready = '0;
        if (m_valid) req_ready[gnt_idx] = m_ready;
        rsp_valid = '0;
        if (reset_n && s_valid && !tag_empty) rsp_valid[head] = 1'b1;
        // With no tag pending, responses are orphans and are swallowed.
        s_ready     = reset_n && (tag_empty || rsp_ready[head]);
        rsp_data    = s_data;
        rsp_addr    = s_addr;
        outstanding = cnt_q;
        err_orphan  = err_orphan_q;
    end

    assign accept = m_valid && m_ready;
    assign push   = accept && !m_we;
    assign pop    = s_valid && s_ready && !tag_empty;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) rr_ptr_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
        tag_mem_d = tag_mem_q;
        if (push) tag_mem_d[wr_ptr_q] = gnt_idx;
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        err_orphan_d = err_orphan_q | (s_valid && tag_empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_orphan_q <= err_orphan_d;
            tag_mem_q    <= tag_mem_d;
        end
    end
endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Bench for vmem_port_arbiter: acts as requesters and as a 1-cycle memory slice,
// predicts grants/tags from a queue-based model and scoreboards read responses.
module tb_vmem_port_arbiter;
    localparam int NREQ = 4, AW = 12, DW = 32, TAG_DEPTH = 4;
    localparam int CW = $clog2(TAG_DEPTH+1);

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] r_we, r_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data, m_data, s_data;
    logic [AW-1:0] rsp_addr, m_addr, s_addr;
    logic m_we, m_valid, m_ready, s_valid, s_ready, err_orphan;
    logic [CW-1:0] outstanding;

    logic [AW-1:0] r_addr [NREQ];
    logic [DW-1:0] r_data [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k*AW +: AW] = r_addr[k];
            req_data[k*DW +: DW] = r_data[k];
        end
    end

    vmem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_addr(req_addr), .req_data(req_data), .req_we(r_we), .req_valid(r_valid),
        .req_ready(req_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_addr(m_addr), .m_data(m_data), .m_we(m_we), .m_valid(m_valid), .m_ready(m_ready),
        .s_addr(s_addr), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    typedef struct { int id; logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } sl_t;

    int errors = 0, checks = 0;
    logic [DW-1:0] mem [4096];
    exp_t exp_q[$];
    sl_t  slice_q[$];
    int   tag_q[$];
    int   rr = 0;
    bit   err_m = 0;
    bit   force_orphan = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic arm(int k, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        r_valid[k] = 1'b1;
        r_we[k]    = we;
        r_addr[k]  = a;
        r_data[k]  = d;
    endtask

    task automatic drive_slice();
        if (slice_q.size() > 0) begin
            s_valid = 1'b1;
            s_addr  = slice_q[0].addr;
            s_data  = slice_q[0].data;
        end else begin
            s_valid = force_orphan;
            s_addr  = AW'($urandom);
            s_data  = $urandom;
        end
    endtask

    // One clock: check DUT against the model at negedge, advance the model after posedge.
    task automatic tick();
        int g;
        bit acc, pop, orph, sr;
        logic [NREQ-1:0] exp_rv, exp_rr;
        @(negedge clk);
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (rr + i) % NREQ;
            if (g < 0 && r_valid[k] && (r_we[k] || tag_q.size() < TAG_DEPTH)) g = k;
        end
        chk("m_valid", m_valid, g >= 0);
        if (g >= 0) begin
            chk("m_addr", m_addr, r_addr[g]);
            chk("m_we", m_we, r_we[g]);
            chk("m_data", m_data, r_data[g]);
        end
        acc = (g >= 0) && m_ready;
        exp_rr = '0;
        if (acc) exp_rr[g] = 1'b1;
        chk("req_ready", req_ready, exp_rr);
        sr = (tag_q.size() == 0) ? 1'b1 : rsp_ready[tag_q[0]];
        chk("s_ready", s_ready, sr);
        exp_rv = '0;
        if (s_valid && tag_q.size() > 0) exp_rv[tag_q[0]] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("outstanding", outstanding, tag_q.size());
        chk("err_orphan", err_orphan, err_m);
        pop  = s_valid && sr && tag_q.size() > 0;
        orph = s_valid && tag_q.size() == 0;
        @(posedge clk);
        #1;
        if (s_valid && sr && slice_q.size() > 0) void'(slice_q.pop_front());
        if (pop) void'(tag_q.pop_front());
        if (orph) err_m = 1'b1;
        if (acc) begin
            rr = (g + 1) % NREQ;
            if (r_we[g]) mem[r_addr[g]] = r_data[g];
            else begin
                tag_q.push_back(g);
                exp_q.push_back('{g, r_addr[g], mem[r_addr[g]]});
                slice_q.push_back('{r_addr[g], mem[r_addr[g]]});
            end
            r_valid[g] = 1'b0;
        end
        drive_slice();
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready   = 1'b1;
        rsp_ready = '1;
        while ((r_valid != '0 || tag_q.size() != 0 || slice_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_within_bound", n < 300, 1);
    endtask

    // Scoreboard monitor: consumes expected reads whenever the DUT presents a response.
    always @(negedge clk) begin
        logic [NREQ-1:0] oh;
        if (reset_n === 1'b1 && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b with no read pending at %0t", rsp_valid, $time);
            end else begin
                oh = '0;
                oh[exp_q[0].id] = 1'b1;
                chk("rsp_onehot", rsp_valid, oh);
                chk("rsp_addr", rsp_addr, exp_q[0].addr);
                chk("rsp_data", rsp_data, exp_q[0].data);
                if (rsp_ready[exp_q[0].id]) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        r_valid = '0; r_we = '0; m_ready = 1'b0; rsp_ready = '0;
        s_valid = 1'b0; s_addr = '0; s_data = '0;
        for (int k = 0; k < NREQ; k++) begin r_addr[k] = '0; r_data[k] = '0; end
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        // Reset: outputs forced low even with live inputs.
        #1 reset_n = 1'b0;
        r_valid[2] = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_orphan", err_orphan, 0);
        repeat (2) @(posedge clk);
        #1;
        r_valid = '0; s_valid = 1'b0; reset_n = 1'b1;

        // Single read from req0.
        m_ready = 1'b1; rsp_ready = '1;
        arm(0, 1'b0, 12'h010, 32'h0);
        repeat (3) tick();

        // All requesters reading back-to-back.
        repeat (12) begin
            for (int k = 0; k < NREQ; k++)
                if (!r_valid[k]) arm(k, 1'b0, AW'($urandom_range(0, 63)), $urandom);
            tick();
        end
        drain();

        // Stall with req1 and req2 pending; rr steered to 1 by a req0 write first.
        arm(0, 1'b1, 12'h0a0, 32'hdead_beef);
        tick();
        arm(1, 1'b0, 12'h101, $urandom);
        arm(2, 1'b0, 12'h102, $urandom);
        m_ready = 1'b0;
        repeat (3) tick();
        chk("stall_m_addr", m_addr, 12'h101);
        m_ready = 1'b1;
        repeat (2) tick();
        drain();

        // Fill the tag FIFO; a write still goes through.
        rsp_ready = '0; m_ready = 1'b1; issued = 0;
        arm(3, 1'b1, 12'h055, 32'h1234_5678);
        repeat (10) begin
            if (!r_valid[0] && issued < 5) begin
                arm(0, 1'b0, AW'(12'h020 + issued), $urandom);
                issued++;
            end
            tick();
        end
        chk("full_outstanding", outstanding, TAG_DEPTH);
        chk("full_read_blocked", req_ready[0], 0);
        drain();

        // Randomized traffic.
        repeat (1500) begin
            for (int k = 0; k < NREQ; k++)
                if (!r_valid[k] && $urandom_range(0, 2) == 0)
                    arm(k, $urandom_range(0, 3) == 0, AW'($urandom_range(0, 31)), $urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) rsp_ready[k] = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Orphan response with empty FIFO.
        force_orphan = 1'b1; s_valid = 1'b1;
        tick();
        force_orphan = 1'b0; s_valid = 1'b0;
        repeat (3) tick();
        chk("orphan_sticky", err_orphan, 1);

        // Reset with two reads outstanding and another read waiting.
        rsp_ready = '0;
        arm(0, 1'b0, 12'h030, $urandom);
        tick();
        arm(0, 1'b0, 12'h031, $urandom);
        tick();
        arm(1, 1'b0, 12'h040, $urandom);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_err_orphan", err_orphan, 0);
        tag_q.delete(); exp_q.delete(); rr = 0; err_m = 1'b0; r_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rsp_ready = '1;
        repeat (3) tick();
        chk("late_rsp_orphan", err_orphan, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
